prog_loader: RTL
================

PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter DEPTH, default 128, SHALL set the number of instruction-memory words.
REQ-002 Parameter AW, default 7, SHALL set the instruction-memory address width.
REQ-003 Parameter DW, default 16, SHALL set the instruction word width.
REQ-004 Clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-005 Reset  input  1  SHALL be an asynchronous, active-low reset.
REQ-006 Start  input  1  SHALL request a load; sampled only in IDLE, RUN or ERROR.
REQ-007 Word_Count  input  8  SHALL give the number of program words to load; latched on an accepted Start.
REQ-008 In_Valid  input  1  SHALL mark In_Data as valid.
REQ-009 In_Data  input  DW  SHALL carry a program word or the trailing checksum word.
REQ-010 In_Ready  output  1  SHALL indicate the loader accepts a word this cycle.
REQ-011 IM_W_en  output  1  SHALL be the instruction-memory write strobe.
REQ-012 IM_W_addr  output  AW  SHALL be the instruction-memory write address.
REQ-013 IM_W_data  output  DW  SHALL be the instruction-memory write data.
REQ-014 CPU_Reset_n  output  1  SHALL be the active-low processor reset; low holds the processor.
REQ-015 Checksum  output  16  SHALL be the running sum, modulo 2^16, of the program words accepted in the current load.
REQ-016 Err  output  1  SHALL flag a failed load.
REQ-017 StateOut  output  4  SHALL expose the current FSM state encoding.

Function
REQ-018 FSM states and StateOut encodings SHALL be IDLE=0, LOAD=1, CHECK=2, RUN=3, ERROR=4; all other encodings are unreachable and SHALL return to IDLE.
REQ-019 Start-to-LOAD transition SHALL occur from IDLE, RUN or ERROR when Start=1 and 1<=Word_Count<=DEPTH.
REQ-020 Start-to-LOAD transition SHALL clear the word index, Checksum and Err.
REQ-021 Start with Word_Count=0 or Word_Count>DEPTH SHALL go to ERROR with Err=1 and no memory write.
REQ-022 Start SHALL be ignored in LOAD and CHECK.
REQ-023 In_Ready SHALL be 1 exactly in LOAD and CHECK, as a registered function of state.
REQ-024 A transfer SHALL occur on a rising edge with In_Valid=1 and In_Ready=1; In_Valid=0 stalls without limit and without error.
REQ-025 Each LOAD transfer SHALL produce, on the following cycle, IM_W_en=1 for exactly one cycle with IM_W_addr=word index and IM_W_data=the accepted word.
REQ-026 Each LOAD transfer SHALL increment the word index and add the word to Checksum, modulo 2^16.
REQ-027 IM_W_en SHALL be 0 in every cycle that does not follow a LOAD transfer.
REQ-028 The transfer that brings the index to Word_Count SHALL move the FSM to CHECK; for Word_Count=DEPTH the index SHALL not wrap into a further write.
REQ-029 The single CHECK transfer SHALL NOT write memory and SHALL NOT update Checksum.
REQ-030 The CHECK transfer SHALL go to RUN if its data equals Checksum, else go to ERROR with Err=1.
REQ-031 CPU_Reset_n SHALL be 1 only in RUN; it SHALL go low on the same edge that leaves RUN for LOAD.
REQ-032 Err SHALL remain 1 in ERROR until the next accepted Start or Reset.
REQ-033 Checksum SHALL hold its final value in RUN and ERROR.

Reset
REQ-034 Reset=0 SHALL immediately force state IDLE, StateOut=0, In_Ready=0, IM_W_en=0, IM_W_addr=0, IM_W_data=0, Checksum=0, Err=0, CPU_Reset_n=0, word index 0, latched count 0.
REQ-035 Reset asserted mid-load SHALL abort the load, suppress any pending write strobe, and require a new Start.
REQ-036 Release of Reset SHALL leave the block in IDLE with the processor held in reset.

Verification
REQ-037 Basic load: Word_Count=3, words 0x1234, 0x0001, 0xFFFF, check word 0x1234 -> writes to addresses 0,1,2; Checksum=0x1234; RUN; CPU_Reset_n=1.
REQ-038 Bad check: same words, check word 0x1235 -> ERROR; Err=1; CPU_Reset_n=0; StateOut=4.
REQ-039 Full depth with stalls: Word_Count=128, In_Valid toggled randomly -> 128 writes, addresses 0..127, no address-0 rewrite, CHECK reached, one write per transfer.
REQ-040 Illegal count: Start with Word_Count=0, then with 129 -> ERROR each time; no IM_W_en pulse.
REQ-041 Reset mid-load: Reset=0 after 2 of 5 words -> all outputs at reset values within the same cycle; a subsequent Start reloads from address 0.
REQ-042 Reload from RUN: Start in RUN -> CPU_Reset_n=0 on the transition edge; Checksum=0; StateOut=1.

Source files
------------

// File: rtl/prog_loader.sv
// prog_loader: streams a program into instruction memory, validates a trailing
// checksum word and releases the processor reset only on a good load.
`default_nettype none

module prog_loader #(
  parameter int DEPTH = 128,
  parameter int AW    = 7,
  parameter int DW    = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [7:0]    word_count,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  output logic          im_w_en,
  output logic [AW-1:0] im_w_addr,
  output logic [DW-1:0] im_w_data,
  output logic          cpu_reset_n,
  output logic [15:0]   checksum,
  output logic          err,
  output logic [3:0]    state_out
);

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_LOAD  = 4'd1,
    S_CHECK = 4'd2,
    S_RUN   = 4'd3,
    S_ERROR = 4'd4
  } state_t;

  localparam logic [8:0] DEPTH_W = 9'(DEPTH);

  state_t      state, next_state;
  logic [7:0]  idx, count;
  logic [15:0] word16;
  logic        xfer, start_ok, last_word;
  logic        load_start, load_xfer, set_err;

  assign xfer      = in_valid & in_ready;
  assign word16    = 16'(in_data);
  assign start_ok  = (word_count != 8'd0) && ({1'b0, word_count} <= DEPTH_W);
  assign last_word = ((idx + 8'd1) == count);
  assign state_out = state;

  always_comb begin
    next_state = state;
    load_start = 1'b0;
    load_xfer  = 1'b0;
    set_err    = 1'b0;
    case (state)
      S_IDLE, S_RUN, S_ERROR: begin
        if (start) begin
          if (start_ok) begin
            next_state = S_LOAD;
            load_start = 1'b1;
          end else begin
            next_state = S_ERROR;
            set_err    = 1'b1;
          end
        end
      end
      S_LOAD: begin
        if (xfer) begin
          load_xfer = 1'b1;
          if (last_word) next_state = S_CHECK;
        end
      end
      S_CHECK: begin
        if (xfer) begin
          if (word16 == checksum) begin
            next_state = S_RUN;
          end else begin
            next_state = S_ERROR;
            set_err    = 1'b1;
          end
        end
      end
      default: next_state = S_IDLE;
    endcase
  end

  // Ready and processor reset are registered from next_state so they track state exactly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      in_ready    <= 1'b0;
      im_w_en     <= 1'b0;
      im_w_addr   <= '0;
      im_w_data   <= '0;
      cpu_reset_n <= 1'b0;
      checksum    <= 16'd0;
      err         <= 1'b0;
      idx         <= 8'd0;
      count       <= 8'd0;
    end else begin
      state       <= next_state;
      in_ready    <= (next_state == S_LOAD) || (next_state == S_CHECK);
      cpu_reset_n <= (next_state == S_RUN);
      im_w_en     <= load_xfer;
      if (load_xfer) begin
        im_w_addr <= idx[AW-1:0];
        im_w_data <= in_data;
        idx       <= idx + 8'd1;
        checksum  <= checksum + word16;
      end
      if (load_start) begin
        idx      <= 8'd0;
        checksum <= 16'd0;
        err      <= 1'b0;
        count    <= word_count;
      end
      if (set_err) err <= 1'b1;
    end
  end

endmodule

`default_nettype wire
